// File: rtl/apb_cfg_master_if.sv
// apb_cfg_master_if: command, response and APB signal bundle for apb_cfg_master.
//   master modport: the requester's view (drives cmd_ready, rsp_*, APB controls).
//   slave  modport: the environment's view (drives cmd_*, rsp_ready, completer returns).
// Ports carried:
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata  command channel
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err/rsp_timeout response channel
//   psel/penable/pwrite/paddr/pwdata/prdata/pready/pslverr APB bus
interface apb_cfg_master_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  rsp_ready,
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output rsp_ready,
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_cfg_master.sv
// apb_cfg_master: runs one command at a time as a single APB transfer
// (SETUP then ACCESS with wait states) and returns data/status on a
// valid/ready response channel.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  apb_cfg_master_if.master (command, response and APB signals)
// Optional feature: define APB_CFG_MASTER_TIMEOUT_EN to abort an ACCESS phase
// after TIMEOUT cycles without pready (reported as rsp_err + rsp_timeout).
module apb_cfg_master #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input logic             clk,
  input logic             rst,
  apb_cfg_master_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic              psel_q,      psel_d;
  logic              penable_q,   penable_d;
  logic              pwrite_q,    pwrite_d;
  logic [ADDR_W-1:0] paddr_q,     paddr_d;
  logic [DATA_W-1:0] pwdata_q,    pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q,   rsp_err_d;
  logic              timeout_hit;

`ifdef APB_CFG_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_timeout_q, rsp_timeout_d;

  // Counter holds the number of waited cycles already elapsed, so this is the
  // TIMEOUT-th waiting cycle; pready in the same cycle still wins.
  assign timeout_hit = (state_q == S_ACCESS) && !bus.pready &&
                       (cnt_q == CNT_W'(TIMEOUT - 1));
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign timeout_hit    = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.cmd_valid) state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: if (bus.pready || timeout_hit) state_d = S_RESP;
      S_RESP:   if (bus.rsp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values; every output is registered below
  always_comb begin
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_CFG_MASTER_TIMEOUT_EN
    cnt_d         = cnt_q;
    rsp_timeout_d = rsp_timeout_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          pwrite_d = bus.cmd_write;
          paddr_d  = bus.cmd_addr;
          pwdata_d = bus.cmd_wdata;
          psel_d   = 1'b1;
`ifdef APB_CFG_MASTER_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      S_SETUP: penable_d = 1'b1;
      S_ACCESS: begin
        if (bus.pready) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          // Writes and failed reads both return zero data
          rsp_rdata_d = (pwrite_q || bus.pslverr) ? '0 : bus.prdata;
          rsp_err_d   = bus.pslverr;
`ifdef APB_CFG_MASTER_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
`endif
        end else if (timeout_hit) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
`ifdef APB_CFG_MASTER_TIMEOUT_EN
          rsp_timeout_d = 1'b1;
`endif
        end else begin
`ifdef APB_CFG_MASTER_TIMEOUT_EN
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      S_RESP: if (bus.rsp_ready) rsp_valid_d = 1'b0;
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_CFG_MASTER_TIMEOUT_EN
      cnt_q         <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_CFG_MASTER_TIMEOUT_EN
      cnt_q         <= cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
`endif
    end
  end

  // cmd_ready is a pure state decode
  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
`ifdef APB_CFG_MASTER_TIMEOUT_EN
  assign bus.rsp_timeout = rsp_timeout_q;
`else
  assign bus.rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_apb_cfg_master.sv
// tb_apb_cfg_master: directed plus randomized commands against apb_cfg_master,
// with the testbench acting as the APB completer and a transaction-level model
// predicting response data, status and latency.
module tb_apb_cfg_master;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  apb_cfg_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  apb_cfg_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] comp_mem [logic [31:0]];
  logic [31:0] ref_mem  [logic [31:0]];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] blank_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Transaction-level prediction: number of ACCESS cycles, response fields,
  // and the effect on register contents.
  task automatic model_cmd(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                           input int waits, input logic err,
                           output int n_acc, output logic [31:0] e_rd,
                           output logic e_err, output logic e_to);
    logic to;
`ifdef APB_CFG_MASTER_TIMEOUT_EN
    to = (waits >= int'(TIMEOUT));
`else
    to = 1'b0;
`endif
    n_acc = to ? int'(TIMEOUT) : waits + 1;
    e_to  = to;
    e_err = to | err;
    if (wr || e_err) e_rd = 32'h0;
    else             e_rd = ref_mem.exists(a) ? ref_mem[a] : blank_word(a);
    if (wr && !e_err) ref_mem[a] = wd;
  endtask

  task automatic run_cmd(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input int waits, input logic err, input int hold);
    int          n_acc;
    logic [31:0] e_rd;
    logic        e_err, e_to;
    model_cmd(wr, a, wd, waits, err, n_acc, e_rd, e_err, e_to);

    @(negedge clk);
    check("idle_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = wd;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'($urandom);
    bus.cmd_addr  = $urandom;
    bus.cmd_wdata = $urandom;
    bus.pready    = 1'b0;
    bus.prdata    = $urandom;
    bus.rsp_ready = 1'($urandom);
    check("setup_psel",      64'(bus.psel),      64'd1);
    check("setup_penable",   64'(bus.penable),   64'd0);
    check("setup_paddr",     64'(bus.paddr),     64'(a));
    check("setup_pwrite",    64'(bus.pwrite),    64'(wr));
    check("setup_pwdata",    64'(bus.pwdata),    64'(wd));
    check("setup_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    @(posedge clk); #1;

    for (int k = 0; k < n_acc; k++) begin
      check("access_psel",    64'(bus.psel),      64'd1);
      check("access_penable", 64'(bus.penable),   64'd1);
      check("access_paddr",   64'(bus.paddr),     64'(a));
      check("access_pwrite",  64'(bus.pwrite),    64'(wr));
      check("access_pwdata",  64'(bus.pwdata),    64'(wd));
      check("access_rsp_vld", 64'(bus.rsp_valid), 64'd0);
      check("access_cmd_rdy", 64'(bus.cmd_ready), 64'd0);
      bus.rsp_ready = 1'($urandom);
      if (k == waits) begin
        bus.pready  = 1'b1;
        bus.pslverr = err;
        if (wr) begin
          if (!err) comp_mem[bus.paddr] = bus.pwdata;
          bus.prdata = $urandom;
        end else begin
          bus.prdata = comp_mem.exists(bus.paddr) ? comp_mem[bus.paddr] : blank_word(bus.paddr);
        end
      end else begin
        bus.pready  = 1'b0;
        bus.pslverr = 1'($urandom);
        bus.prdata  = $urandom;
      end
      @(posedge clk); #1;
    end
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;
    bus.prdata    = $urandom;
    bus.rsp_ready = 1'b0;

    for (int h = 0; h <= hold; h++) begin
      check("resp_valid",   64'(bus.rsp_valid),   64'd1);
      check("resp_rdata",   64'(bus.rsp_rdata),   64'(e_rd));
      check("resp_err",     64'(bus.rsp_err),     64'(e_err));
      check("resp_timeout", 64'(bus.rsp_timeout), 64'(e_to));
      check("resp_psel",    64'(bus.psel),        64'd0);
      check("resp_penable", 64'(bus.penable),     64'd0);
      check("resp_paddr",   64'(bus.paddr),       64'(a));
      check("resp_cmd_rdy", 64'(bus.cmd_ready),   64'd0);
      if (h < hold) begin
        @(posedge clk); #1;
      end
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check("done_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("done_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check("done_psel",      64'(bus.psel),      64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.prdata    = '0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;
    comp_mem[32'h5000_0004] = 32'h0403_0201;
    ref_mem[32'h5000_0004]  = 32'h0403_0201;

    // Command presented during reset must not be taken
    #3;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h5000_0010;
    bus.cmd_wdata = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_psel",        64'(bus.psel),        64'd0);
    check("rst_penable",     64'(bus.penable),     64'd0);
    check("rst_pwrite",      64'(bus.pwrite),      64'd0);
    check("rst_paddr",       64'(bus.paddr),       64'd0);
    check("rst_pwdata",      64'(bus.pwdata),      64'd0);
    check("rst_rsp_valid",   64'(bus.rsp_valid),   64'd0);
    check("rst_rsp_rdata",   64'(bus.rsp_rdata),   64'd0);
    check("rst_rsp_err",     64'(bus.rsp_err),     64'd0);
    check("rst_rsp_timeout", 64'(bus.rsp_timeout), 64'd0);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    rst           = 1'b0;
    @(posedge clk); #1;
    check("post_rst_psel",      64'(bus.psel),      64'd0);
    check("post_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);

    // Directed cases
    run_cmd(1'b1, 32'h5000_0000, 32'hA5A5_A5A5, 0, 1'b0, 0);
    run_cmd(1'b0, 32'h5000_0004, 32'h0,         0, 1'b0, 0);
    run_cmd(1'b0, 32'h5000_0000, 32'h1234_5678, 3, 1'b0, 0);
    run_cmd(1'b1, 32'h5000_000C, 32'hCAFE_F00D, 1, 1'b1, 5);
    run_cmd(1'b0, 32'h5000_000C, 32'h0,         0, 1'b0, 1);
    run_cmd(1'b0, 32'h5000_0004, 32'h0,         0, 1'b1, 0);
    run_cmd(1'b0, 32'h5000_0004, 32'h0,         10, 1'b0, 0);
    run_cmd(1'b0, 32'h5000_0000, 32'h0,         int'(TIMEOUT) - 1, 1'b0, 0);

    // Reset in the middle of ACCESS abandons the transfer
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h5000_0004;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.pready    = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_penable", 64'(bus.penable), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_psel",      64'(bus.psel),      64'd0);
    check("midrst_penable",   64'(bus.penable),   64'd0);
    check("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("midrst_paddr",     64'(bus.paddr),     64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_no_rsp", 64'(bus.rsp_valid), 64'd0);
    run_cmd(1'b0, 32'h5000_0008, 32'h0, 0, 1'b0, 0);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      logic        wr;
      logic [31:0] a;
      wr = 1'($urandom_range(0, 1));
      a  = 32'h5000_0000 + 32'($urandom_range(0, 7) * 4);
      run_cmd(wr, a, $urandom, int'($urandom_range(0, 6)),
              ($urandom_range(0, 4) == 0), int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/apb_cfg_master.md
# apb_cfg_master

Requester side of the APB configuration bus. The block accepts single read or write commands on a valid/ready command port. It runs each command as one APB transfer (SETUP then ACCESS, with wait states) against the configuration-register completers at 0x5000_0000. It returns read data and error status on a valid/ready response port. It sits between the system control logic (or test harness) and the APB config slaves, and issues one transfer at a time.

## Interface
Parameters:
- ADDR_W, 32, paddr / cmd_addr width
- DATA_W, 32, pwdata / prdata / cmd_wdata / rsp_rdata width
- TIMEOUT, 255, maximum ACCESS-phase cycles waited for pready (used only with the timeout option); legal range 1..65535

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data (ignored for reads)
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  DATA_W  read data; 0 for writes and on error/timeout
- rsp_err  out  1  pslverr or timeout occurred
- rsp_timeout  out  1  transfer aborted by timeout (always 0 without the timeout option)
- psel, penable, pwrite  out  1  APB control
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- prdata  in  DATA_W  APB read data
- pready  in  1  completer ready; tie to 1 for completers without wait states
- pslverr  in  1  completer error; tie to 0 if unused

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. Reset state is IDLE.
- IDLE:
  - cmd_ready = 1.
  - When cmd_valid is 1, latch cmd_write/cmd_addr/cmd_wdata into pwrite/paddr/pwdata and go to SETUP.
- SETUP: psel = 1, penable = 0; go to ACCESS unconditionally.
- ACCESS:
  - psel = 1, penable = 1.
  - When pready = 1:
    - capture rsp_rdata = (pwrite ? 0 : prdata) and rsp_err = pslverr;
    - drop psel/penable;
    - go to RESP.
  - While pready = 0, hold all APB outputs stable.
- RESP:
  - rsp_valid = 1, held with its data stable until rsp_ready = 1.
  - On the handshake, go to IDLE.
  - rsp_ready sampled outside RESP is ignored.
- Read data is captured on the ACCESS completion edge, not during SETUP. paddr/pwrite/pwdata keep their last values after the transfer; only psel/penable return to 0.
- Exactly one outstanding transfer; there is no command queuing. cmd_ready is 0 in SETUP, ACCESS and RESP.
- A read with pslverr = 1 returns rsp_rdata = 0 and rsp_err = 1.
- Reset asserted mid-transfer: all outputs go to reset values immediately, the transfer is abandoned, and no response is produced.
- Reset values: psel 0, penable 0, pwrite 0, paddr 0, pwdata 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, rsp_timeout 0. cmd_ready is 1 in IDLE once rst deasserts; commands presented while rst = 1 are not accepted.

## Timing
- Command handshake at edge N → SETUP during N+1 → ACCESS during N+2.
- With pready = 1 in the first ACCESS cycle, rsp_valid = 1 from edge N+3.
- Each pready = 0 ACCESS cycle adds one cycle of latency.
- Minimum command-to-command period is 4 cycles (rsp_ready tied to 1).
- All outputs are registered except cmd_ready, which is decoded from the state register with no combinational path from inputs.

## Configuration
- APB_CFG_MASTER_TIMEOUT_EN defined:
  - An ACCESS-phase cycle counter (width clog2(TIMEOUT+1)) is cleared on entry to SETUP and increments in each ACCESS cycle with pready = 0.
  - When it reaches TIMEOUT with pready still 0, the transfer is aborted: psel/penable drop and the FSM goes to RESP with rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
  - pready = 1 in the same cycle the counter reaches TIMEOUT wins: a normal completion with no timeout.
- Undefined: no counter is built, ACCESS waits for pready indefinitely, and rsp_timeout is tied to 0.

## Test plan
- Write 0x5000_0000 data 0xA5A5_A5A5, pready = 1 → SETUP at N+1, ACCESS at N+2 with paddr/pwdata correct; rsp_valid at N+3 with rsp_err = 0, rsp_rdata = 0.
- Read 0x5000_0004, completer returns 0x0403_0201 with pready = 1 → rsp_rdata = 0x0403_0201, rsp_err = 0; psel/penable back to 0 at N+3.
- Read with pready low for 3 ACCESS cycles → APB outputs stable throughout; rsp_valid at N+6; cmd_ready 0 until the response handshake.
- Write with pslverr = 1, and rsp_ready held 0 for 5 cycles → rsp_err = 1, and rsp_valid plus data held stable until rsp_ready; then IDLE with cmd_ready = 1.
- With APB_CFG_MASTER_TIMEOUT_EN and TIMEOUT = 4, pready never asserted → abort after 4 waiting ACCESS cycles with rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0. Repeat with pready rising on the 4th cycle → normal completion.
- Assert rst during ACCESS → psel/penable/rsp_valid go to 0 asynchronously; after release a new read of 0x5000_0008 completes normally.
